// File: rtl/serial_adder_param.sv
// Multi-cycle adder/subtractor: one WIDTH-bit operand pair is added LSB-first,
// BITS_PER_CYCLE bits per cycle, through a ripple full-adder slice.
module serial_adder_param #(
  parameter int unsigned WIDTH          = 8,
  parameter int unsigned BITS_PER_CYCLE = 1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             cin,
  input  logic             sub,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] sum,
  output logic             cout,
  output logic             overflow
);

  localparam int unsigned N     = WIDTH / BITS_PER_CYCLE;
  localparam int unsigned CNT_W = (N > 1) ? $clog2(N) : 1;
  localparam logic [CNT_W-1:0] LAST = CNT_W'(N - 1);

  if (WIDTH < 1 || BITS_PER_CYCLE < 1 || (WIDTH % BITS_PER_CYCLE) != 0) begin : g_bad_params
    $error("serial_adder_param: BITS_PER_CYCLE must divide WIDTH exactly");
  end

  typedef enum logic [1:0] {ST_IDLE, ST_RUN, ST_DONE} state_t;

  state_t                    state_q, state_d;
  logic [WIDTH-1:0]          a_q, a_d, b_q, b_d, sum_d;
  logic                      carry_q, carry_d;
  logic [CNT_W-1:0]          cnt_q, cnt_d;
  logic                      in_ready_d, out_valid_d, cout_d, overflow_d;

  logic [31:0]               off;
  logic [WIDTH-1:0]          a_sh, b_sh, chunk_mask, chunk_ext;
  logic [BITS_PER_CYCLE-1:0] a_chunk, b_chunk, s_chunk;
  logic [BITS_PER_CYCLE:0]   rc;

  // Ripple full-adder slice over the chunk selected by cnt_q
  always_comb begin
    off        = 32'(cnt_q) * BITS_PER_CYCLE;
    a_sh       = a_q >> off;
    b_sh       = b_q >> off;
    a_chunk    = a_sh[BITS_PER_CYCLE-1:0];
    b_chunk    = b_sh[BITS_PER_CYCLE-1:0];
    rc         = '0;
    s_chunk    = '0;
    rc[0]      = carry_q;
    for (int i = 0; i < int'(BITS_PER_CYCLE); i++) begin
      s_chunk[i] = a_chunk[i] ^ b_chunk[i] ^ rc[i];
      rc[i+1]    = (a_chunk[i] & b_chunk[i]) | (rc[i] & (a_chunk[i] ^ b_chunk[i]));
    end
    chunk_mask = '0;
    chunk_mask[BITS_PER_CYCLE-1:0] = '1;
    chunk_ext  = '0;
    chunk_ext[BITS_PER_CYCLE-1:0]  = s_chunk;
  end

  // Next-state and next-output logic
  always_comb begin
    state_d     = state_q;
    a_d         = a_q;
    b_d         = b_q;
    carry_d     = carry_q;
    cnt_d       = cnt_q;
    sum_d       = sum;
    cout_d      = cout;
    overflow_d  = overflow;
    in_ready_d  = in_ready;
    out_valid_d = out_valid;
    case (state_q)
      ST_IDLE: begin
        if (in_valid) begin
          a_d        = a;
          b_d        = sub ? ~b : b;
          carry_d    = sub ? 1'b1 : cin;
          cnt_d      = '0;
          in_ready_d = 1'b0;
          state_d    = ST_RUN;
        end
      end
      ST_RUN: begin
        sum_d   = (sum & ~(chunk_mask << off)) | (chunk_ext << off);
        carry_d = rc[BITS_PER_CYCLE];
        cnt_d   = cnt_q + CNT_W'(1);
        if (cnt_q == LAST) begin
          cnt_d       = '0;
          cout_d      = rc[BITS_PER_CYCLE];
          overflow_d  = (a_q[WIDTH-1] == b_q[WIDTH-1]) && (sum_d[WIDTH-1] != a_q[WIDTH-1]);
          out_valid_d = 1'b1;
          state_d     = ST_DONE;
        end
      end
      ST_DONE: begin
        if (out_ready) begin
          out_valid_d = 1'b0;
          in_ready_d  = 1'b1;
          state_d     = ST_IDLE;
        end
      end
      default: begin
        out_valid_d = 1'b0;
        in_ready_d  = 1'b1;
        state_d     = ST_IDLE;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= ST_IDLE;
      a_q       <= '0;
      b_q       <= '0;
      carry_q   <= 1'b0;
      cnt_q     <= '0;
      sum       <= '0;
      cout      <= 1'b0;
      overflow  <= 1'b0;
      in_ready  <= 1'b1;
      out_valid <= 1'b0;
    end else begin
      state_q   <= state_d;
      a_q       <= a_d;
      b_q       <= b_d;
      carry_q   <= carry_d;
      cnt_q     <= cnt_d;
      sum       <= sum_d;
      cout      <= cout_d;
      overflow  <= overflow_d;
      in_ready  <= in_ready_d;
      out_valid <= out_valid_d;
    end
  end

endmodule

// File: tb/tb_serial_adder_param.sv
// Directed and randomised checks of serial_adder_param at several
// WIDTH/BITS_PER_CYCLE settings.
module tb_serial_adder_param;

  logic clk;
  logic rst;
  int   checks;
  int   errors;

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // WIDTH=8, BPC=1
  logic       iv0, rdy0, ov0, ordy0, cin0, sub0, c0, o0;
  logic [7:0] a0, b0, s0;
  // WIDTH=8, BPC=4
  logic       iv1, rdy1, ov1, ordy1, cin1, sub1, c1, o1;
  logic [7:0] a1, b1, s1;
  // WIDTH=32, BPC=8
  logic        iv2, rdy2, ov2, ordy2, cin2, sub2, c2, o2;
  logic [31:0] a2, b2, s2;
  // WIDTH=1, BPC=1
  logic       iv3, rdy3, ov3, ordy3, cin3, sub3, c3, o3;
  logic [0:0] a3, b3, s3;

  serial_adder_param #(.WIDTH(8), .BITS_PER_CYCLE(1)) u_d0 (
    .clk(clk), .rst(rst), .in_valid(iv0), .in_ready(rdy0), .a(a0), .b(b0), .cin(cin0),
    .sub(sub0), .out_valid(ov0), .out_ready(ordy0), .sum(s0), .cout(c0), .overflow(o0));
  serial_adder_param #(.WIDTH(8), .BITS_PER_CYCLE(4)) u_d1 (
    .clk(clk), .rst(rst), .in_valid(iv1), .in_ready(rdy1), .a(a1), .b(b1), .cin(cin1),
    .sub(sub1), .out_valid(ov1), .out_ready(ordy1), .sum(s1), .cout(c1), .overflow(o1));
  serial_adder_param #(.WIDTH(32), .BITS_PER_CYCLE(8)) u_d2 (
    .clk(clk), .rst(rst), .in_valid(iv2), .in_ready(rdy2), .a(a2), .b(b2), .cin(cin2),
    .sub(sub2), .out_valid(ov2), .out_ready(ordy2), .sum(s2), .cout(c2), .overflow(o2));
  serial_adder_param #(.WIDTH(1), .BITS_PER_CYCLE(1)) u_d3 (
    .clk(clk), .rst(rst), .in_valid(iv3), .in_ready(rdy3), .a(a3), .b(b3), .cin(cin3),
    .sub(sub3), .out_valid(ov3), .out_ready(ordy3), .sum(s3), .cout(c3), .overflow(o3));

  typedef struct {
    logic [7:0] a;
    logic [7:0] b;
    logic       cin;
    logic       sub;
    logic [7:0] s;
    logic       c;
    logic       o;
  } vec8_t;

  vec8_t vecs[9];

  task automatic check(input string name, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got %0h expected %0h", name, got, exp);
    end
  endtask

  // One transaction on the 8/1 instance, optionally stalling `stall` cycles in DONE
  task automatic txn8(input string tag, input vec8_t v, input int stall);
    int cyc;
    cyc = 0;
    while (!rdy0 && cyc < 20) begin @(posedge clk); #1; cyc++; end
    check({tag, " in_ready"}, 64'(rdy0), 64'(1));
    a0 = v.a; b0 = v.b; cin0 = v.cin; sub0 = v.sub; iv0 = 1'b1;
    @(posedge clk); #1;
    iv0 = 1'b0; a0 = ~v.a; b0 = 8'h5A; cin0 = ~v.cin; sub0 = ~v.sub;
    cyc = 0;
    while (!ov0 && cyc < 40) begin @(posedge clk); #1; cyc++; end
    check({tag, " latency"}, 64'(cyc), 64'(8));
    check({tag, " sum"}, 64'(s0), 64'(v.s));
    check({tag, " cout"}, 64'(c0), 64'(v.c));
    check({tag, " ovf"}, 64'(o0), 64'(v.o));
    for (int k = 0; k < stall; k++) begin
      @(posedge clk); #1;
      check({tag, " stall valid"}, 64'(ov0), 64'(1));
      check({tag, " stall sum"}, 64'(s0), 64'(v.s));
      check({tag, " stall in_ready"}, 64'(rdy0), 64'(0));
    end
    ordy0 = 1'b1;
    @(posedge clk); #1;
    ordy0 = 1'b0;
    check({tag, " valid drop"}, 64'(ov0), 64'(0));
    check({tag, " ready back"}, 64'(rdy0), 64'(1));
  endtask

  initial begin
    int          cyc;
    logic [31:0] ra, rb, rbb;
    logic        rcin, rsub, eo, seen;
    logic [32:0] full;
    vec8_t       bp;
    vec8_t       fresh;
    logic [3:0]  w1[2];   // {a, b, cin, sub}
    logic [2:0]  w1e[2];  // {sum, cout, ovf}

    checks = 0; errors = 0;
    vecs[0] = '{8'hFF, 8'h01, 1'b0, 1'b0, 8'h00, 1'b1, 1'b0};
    vecs[1] = '{8'h7F, 8'h01, 1'b0, 1'b0, 8'h80, 1'b0, 1'b1};
    vecs[2] = '{8'h80, 8'hFF, 1'b1, 1'b0, 8'h80, 1'b1, 1'b0};
    vecs[3] = '{8'h05, 8'h07, 1'b1, 1'b1, 8'hFE, 1'b0, 1'b0};
    vecs[4] = '{8'h80, 8'h01, 1'b0, 1'b1, 8'h7F, 1'b1, 1'b1};
    vecs[5] = '{8'h00, 8'h00, 1'b0, 1'b0, 8'h00, 1'b0, 1'b0};
    vecs[6] = '{8'h55, 8'hAA, 1'b1, 1'b0, 8'h00, 1'b1, 1'b0};
    vecs[7] = '{8'h00, 8'h01, 1'b0, 1'b1, 8'hFF, 1'b0, 1'b0};
    vecs[8] = '{8'h7F, 8'hFF, 1'b0, 1'b1, 8'h80, 1'b0, 1'b1};
    bp      = '{8'h3C, 8'h0F, 1'b1, 1'b0, 8'h4C, 1'b0, 1'b0};
    fresh   = '{8'h10, 8'h20, 1'b0, 1'b0, 8'h30, 1'b0, 1'b0};

    iv0 = 0; ordy0 = 0; a0 = '0; b0 = '0; cin0 = 0; sub0 = 0;
    iv1 = 0; ordy1 = 0; a1 = '0; b1 = '0; cin1 = 0; sub1 = 0;
    iv2 = 0; ordy2 = 0; a2 = '0; b2 = '0; cin2 = 0; sub2 = 0;
    iv3 = 0; ordy3 = 0; a3 = '0; b3 = '0; cin3 = 0; sub3 = 0;
    rst = 1'b1;
    repeat (2) @(posedge clk);
    #1 rst = 1'b0;

    check("rst in_ready", 64'(rdy0), 64'(1));
    check("rst out_valid", 64'(ov0), 64'(0));
    check("rst sum", 64'(s0), 64'(0));
    check("rst cout", 64'(c0), 64'(0));
    check("rst ovf", 64'(o0), 64'(0));

    for (int i = 0; i < 9; i++) txn8($sformatf("vec%0d", i), vecs[i], 0);

    // Backpressure, then a back-to-back transaction
    txn8("backpressure", bp, 5);
    txn8("back2back", vecs[1], 0);

    // Reset during the third RUN cycle discards the transaction
    a0 = 8'h33; b0 = 8'h44; iv0 = 1'b1;
    @(posedge clk); #1;
    iv0 = 1'b0;
    repeat (2) begin @(posedge clk); #1; end
    rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
    check("midrst in_ready", 64'(rdy0), 64'(1));
    check("midrst out_valid", 64'(ov0), 64'(0));
    check("midrst sum", 64'(s0), 64'(0));
    seen = 1'b0;
    repeat (10) begin @(posedge clk); #1; seen = seen | ov0; end
    check("midrst no pulse", 64'(seen), 64'(0));
    txn8("fresh", fresh, 0);

    // WIDTH=8, BPC=4
    a1 = 8'hAB; b1 = 8'h55; cin1 = 1'b1; sub1 = 1'b0; iv1 = 1'b1;
    @(posedge clk); #1;
    iv1 = 1'b0;
    cyc = 0;
    while (!ov1 && cyc < 40) begin @(posedge clk); #1; cyc++; end
    check("bpc4 latency", 64'(cyc), 64'(2));
    check("bpc4 sum", 64'(s1), 64'(8'h01));
    check("bpc4 cout", 64'(c1), 64'(1));
    check("bpc4 ovf", 64'(o1), 64'(0));
    ordy1 = 1'b1;
    @(posedge clk); #1;
    ordy1 = 1'b0;

    // WIDTH=1: 1+1+1 -> 1,c1,o0 ; 0-1 -> 1,c0,o1
    w1[0] = 4'b1110; w1e[0] = 3'b110;
    w1[1] = 4'b0101; w1e[1] = 3'b101;
    for (int i = 0; i < 2; i++) begin
      a3 = w1[i][3:3]; b3 = w1[i][2:2]; cin3 = w1[i][1]; sub3 = w1[i][0]; iv3 = 1'b1;
      @(posedge clk); #1;
      iv3 = 1'b0;
      cyc = 0;
      while (!ov3 && cyc < 40) begin @(posedge clk); #1; cyc++; end
      check($sformatf("w1 v%0d latency", i), 64'(cyc), 64'(1));
      check($sformatf("w1 v%0d result", i), 64'({s3, c3, o3}), 64'(w1e[i]));
      ordy3 = 1'b1;
      @(posedge clk); #1;
      ordy3 = 1'b0;
    end

    // WIDTH=32, BPC=8 against a reference model
    for (int i = 0; i < 1000; i++) begin
      ra = $urandom; rb = $urandom; rcin = 1'($urandom_range(0, 1)); rsub = 1'($urandom_range(0, 1));
      rbb  = rsub ? ~rb : rb;
      full = {1'b0, ra} + {1'b0, rbb} + 33'(rsub ? 1'b1 : rcin);
      eo   = (ra[31] == rbb[31]) && (full[31] != ra[31]);
      cyc = 0;
      while (!rdy2 && cyc < 20) begin @(posedge clk); #1; cyc++; end
      a2 = ra; b2 = rb; cin2 = rcin; sub2 = rsub; iv2 = 1'b1;
      @(posedge clk); #1;
      iv2 = 1'b0; a2 = ~ra;
      cyc = 0;
      while (!ov2 && cyc < 40) begin @(posedge clk); #1; cyc++; end
      check($sformatf("w32 r%0d latency", i), 64'(cyc), 64'(4));
      check($sformatf("w32 r%0d result", i), 64'({c2, s2, o2}), 64'({full, eo}));
      ordy2 = 1'b1;
      @(posedge clk); #1;
      ordy2 = 1'b0;
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
